// File: rtl/line_mem_pkg.sv
// Shared types for the line memory model: memory command encoding, FSM states
// and the words-per-line helper used to size the word counter.
package line_mem_pkg;

    typedef enum logic [1:0] {
        C2_NOP        = 2'd0,
        C2_RESPONSE   = 2'd1,
        C2_READ_LINE  = 2'd2,
        C2_WRITE_LINE = 2'd3
    } cmd2_t;

    typedef enum logic [2:0] {
        IDLE,
        WR_COLLECT,
        WAIT,
        RD_SEND,
        WR_ACK
    } state_t;

    function automatic int words_per_line(input int line_bytes, input int bus);
        return (line_bytes * 8) / bus;
    endfunction

endpackage

// File: rtl/line_mem_if.sv
// Split in/out/oe view of the shared memory bus between the cache (master)
// and the line memory (slave).
interface line_mem_if #(
    parameter int BUS_SIZE  = 16,
    parameter int ADDR_SIZE = 15
);
    import line_mem_pkg::*;

    logic [ADDR_SIZE-1:0] mem_address;
    cmd2_t                mem_cmd_in;
    cmd2_t                mem_cmd_out;
    logic                 mem_cmd_oe;
    logic [BUS_SIZE-1:0]  mem_data_in;
    logic [BUS_SIZE-1:0]  mem_data_out;
    logic                 mem_data_oe;
    logic                 busy;

    modport master (
        output mem_address, mem_cmd_in, mem_data_in,
        input  mem_cmd_out, mem_cmd_oe, mem_data_out, mem_data_oe, busy
    );

    modport slave (
        input  mem_address, mem_cmd_in, mem_data_in,
        output mem_cmd_out, mem_cmd_oe, mem_data_out, mem_data_oe, busy
    );

endinterface

// File: rtl/line_mem_array.sv
// Line-wide storage: one synchronous line write port, one combinational line read port.
// Initial contents are random (seeded) when LINE_MEM_RAND_INIT_EN is defined, zeros otherwise.
module line_mem_array #(
    parameter int NUM_LINES = 32768,
    parameter int LINE_BITS = 128,
    parameter int IDX_W     = 15,
    parameter int SEED      = 225526
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [IDX_W-1:0]     i_wIdx,
    input  logic [LINE_BITS-1:0] i_wData,
    input  logic [IDX_W-1:0]     i_rIdx,
    output logic [LINE_BITS-1:0] o_rData
);
    import line_mem_pkg::*;

    logic [LINE_BITS-1:0] r_mem [NUM_LINES];

    // Contents are never touched by reset, only by this load and by committed writes.
`ifdef LINE_MEM_RAND_INIT_EN
    initial begin : randInit
        integer seedVar;
        seedVar = SEED;
        for (int l = 0; l < NUM_LINES; l++) begin
            for (int b = 0; b < LINE_BITS / 8; b++) begin
                r_mem[l][8*b +: 8] <= 8'($random(seedVar) & 8'hFF);
            end
        end
    end
`else
    initial begin : zeroInit
        for (int l = 0; l < NUM_LINES; l++) begin
            r_mem[l] <= '0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wIdx] <= i_wData;
        end
    end

    assign o_rData = r_mem[i_rIdx];

endmodule

// File: rtl/line_mem.sv
// Parametrised main-memory model serving whole cache lines over the 2-bit command bus.
// Optional random initial contents via LINE_MEM_RAND_INIT_EN (handled in line_mem_array).
module line_mem #(
    parameter int BUS_SIZE          = 16,
    parameter int MEM_ADDR_SIZE     = 19,
    parameter int CACHE_OFFSET_SIZE = 4,
    parameter int CACHE_LINE_SIZE   = 16,
    parameter int NUM_LINES         = 2 ** (MEM_ADDR_SIZE - CACHE_OFFSET_SIZE),
    parameter int MEM_LATENCY       = 100,
    parameter int SEED              = 225526
) (
    input  logic      clk,
    input  logic      reset,
    line_mem_if.slave bus
);
    import line_mem_pkg::*;

    localparam int W         = words_per_line(CACHE_LINE_SIZE, BUS_SIZE);
    localparam int LINE_BITS = CACHE_LINE_SIZE * 8;
    localparam int IDX_W     = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int LAT_W     = $clog2(MEM_LATENCY + 1);
    localparam int WC_W      = $clog2(W + 1);

    state_t                        r_state;
    logic                          r_isRead;
    logic [IDX_W-1:0]              r_idx;
    logic [LAT_W-1:0]              r_lat;
    logic [WC_W-1:0]               r_word;
    logic [LINE_BITS-BUS_SIZE-1:0] r_wrBuf;
    cmd2_t                         r_cmdOut;
    logic                          r_cmdOe;
    logic [BUS_SIZE-1:0]           r_dataOut;
    logic                          r_dataOe;
    logic                          r_busy;

    logic [IDX_W-1:0]              w_reqIdx;
    logic                          w_we;
    logic [LINE_BITS-1:0]          w_wrLine;
    logic [LINE_BITS-1:0]          w_rdLine;

    assign w_reqIdx = IDX_W'(bus.mem_address % NUM_LINES);

    // The last word is never buffered: it goes straight into the array on the edge that samples it.
    assign w_we     = (r_state == WR_COLLECT) && (r_word == WC_W'(W - 1));
    assign w_wrLine = {bus.mem_data_in, r_wrBuf};

    line_mem_array #(
        .NUM_LINES (NUM_LINES),
        .LINE_BITS (LINE_BITS),
        .IDX_W     (IDX_W),
        .SEED      (SEED)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_wIdx  (r_idx),
        .i_wData (w_wrLine),
        .i_rIdx  (r_idx),
        .o_rData (w_rdLine)
    );

    // r_lat counts edges since the request edge; the response starts when it reaches MEM_LATENCY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_isRead  <= 1'b0;
            r_idx     <= '0;
            r_lat     <= '0;
            r_word    <= '0;
            r_wrBuf   <= '0;
            r_cmdOut  <= C2_NOP;
            r_cmdOe   <= 1'b0;
            r_dataOut <= '0;
            r_dataOe  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.mem_cmd_in == C2_READ_LINE) begin
                        r_state  <= WAIT;
                        r_isRead <= 1'b1;
                        r_idx    <= w_reqIdx;
                        r_lat    <= LAT_W'(1);
                        r_busy   <= 1'b1;
                    end else if (bus.mem_cmd_in == C2_WRITE_LINE) begin
                        r_state              <= WR_COLLECT;
                        r_isRead             <= 1'b0;
                        r_idx                <= w_reqIdx;
                        r_wrBuf[BUS_SIZE-1:0] <= bus.mem_data_in;
                        r_word               <= WC_W'(1);
                        r_lat                <= LAT_W'(1);
                        r_busy               <= 1'b1;
                    end
                end
                WR_COLLECT: begin
                    r_lat <= r_lat + 1'b1;
                    if (r_word == WC_W'(W - 1)) begin
                        r_state <= WAIT;
                        r_word  <= '0;
                    end else begin
                        r_wrBuf[r_word*BUS_SIZE +: BUS_SIZE] <= bus.mem_data_in;
                        r_word                               <= r_word + 1'b1;
                    end
                end
                WAIT: begin
                    if (r_lat == LAT_W'(MEM_LATENCY)) begin
                        r_cmdOut <= C2_RESPONSE;
                        r_cmdOe  <= 1'b1;
                        if (r_isRead) begin
                            r_state   <= RD_SEND;
                            r_dataOe  <= 1'b1;
                            r_dataOut <= w_rdLine[BUS_SIZE-1:0];
                            r_word    <= WC_W'(1);
                        end else begin
                            r_state <= WR_ACK;
                        end
                    end else begin
                        r_lat <= r_lat + 1'b1;
                    end
                end
                RD_SEND: begin
                    if (r_word == WC_W'(W)) begin
                        r_state   <= IDLE;
                        r_cmdOut  <= C2_NOP;
                        r_cmdOe   <= 1'b0;
                        r_dataOe  <= 1'b0;
                        r_dataOut <= '0;
                        r_busy    <= 1'b0;
                        r_word    <= '0;
                        r_lat     <= '0;
                    end else begin
                        r_dataOut <= w_rdLine[r_word*BUS_SIZE +: BUS_SIZE];
                        r_word    <= r_word + 1'b1;
                    end
                end
                WR_ACK: begin
                    r_state  <= IDLE;
                    r_cmdOut <= C2_NOP;
                    r_cmdOe  <= 1'b0;
                    r_busy   <= 1'b0;
                    r_lat    <= '0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_cmd_out  = r_cmdOut;
    assign bus.mem_cmd_oe   = r_cmdOe;
    assign bus.mem_data_out = r_dataOut;
    assign bus.mem_data_oe  = r_dataOe;
    assign bus.busy         = r_busy;

endmodule

// File: tb/tb_line_mem.sv
// Directed bench for line_mem (NUM_LINES=1024, W=8, latency 100) with a read-data scoreboard.
// Mirrors LINE_MEM_RAND_INIT_EN in its reference model when the macro is defined.
module tb_line_mem;
    import line_mem_pkg::*;

    localparam int LAT    = 100;
    localparam int W      = 8;
    localparam int NLINES = 1024;
    localparam int SEED   = 225526;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;

    logic [127:0] model [NLINES];
    logic [15:0]  expQ [$];

    always #5 clk = ~clk;

    line_mem_if #(.BUS_SIZE(16), .ADDR_SIZE(15)) memBus ();

    line_mem #(
        .BUS_SIZE          (16),
        .MEM_ADDR_SIZE     (19),
        .CACHE_OFFSET_SIZE (4),
        .CACHE_LINE_SIZE   (16),
        .NUM_LINES         (NLINES),
        .MEM_LATENCY       (LAT),
        .SEED              (SEED)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (memBus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input cmd2_t cmd, input logic [14:0] addr, input logic [15:0] data);
        memBus.mem_cmd_in  = cmd;
        memBus.mem_address = addr;
        memBus.mem_data_in = data;
        tick();
    endtask

    // A read command and a junk address ride along with the data words to show they are ignored.
    task automatic issueWrite(input logic [14:0] addr, input logic [127:0] line, input bit commit,
                              output int reqCycle);
        applyStimulus(C2_WRITE_LINE, addr, line[15:0]);
        reqCycle = cycle;
        checkOutput("wrBusyRise", 32'(memBus.busy), 32'd1);
        for (int k = 1; k < W; k++) begin
            applyStimulus(C2_READ_LINE, 15'h7FFF, line[16*k +: 16]);
        end
        memBus.mem_cmd_in  = C2_NOP;
        memBus.mem_data_in = '0;
        if (commit) model[addr % NLINES] = line;
    endtask

    task automatic issueRead(input logic [14:0] addr, output int reqCycle);
        applyStimulus(C2_READ_LINE, addr, 16'h0000);
        reqCycle = cycle;
        memBus.mem_cmd_in = C2_NOP;
        checkOutput("rdBusyRise", 32'(memBus.busy), 32'd1);
        for (int k = 0; k < W; k++) begin
            expQ.push_back(model[addr % NLINES][16*k +: 16]);
        end
    endtask

    task automatic waitForRsp(input string tag, input int reqCycle, output bit ok);
        while (memBus.mem_cmd_oe !== 1'b1 && (cycle - reqCycle) < LAT + 20) tick();
        checkOutput({tag, "_latency"}, 32'(cycle - reqCycle), 32'(LAT));
        ok = (memBus.mem_cmd_oe === 1'b1);
    endtask

    task automatic checkReadRsp(input string tag, input int reqCycle);
        bit          ok;
        logic [15:0] exp;
        waitForRsp(tag, reqCycle, ok);
        if (ok) begin
            for (int k = 0; k < W; k++) begin
                exp = expQ.pop_front();
                checkOutput({tag, "_cmd"}, 32'(memBus.mem_cmd_out), 32'(C2_RESPONSE));
                checkOutput({tag, "_dataOe"}, 32'(memBus.mem_data_oe), 32'd1);
                checkOutput({tag, "_data"}, 32'(memBus.mem_data_out), 32'(exp));
                tick();
            end
        end
        expQ.delete();
        checkOutput({tag, "_cmdOeDrop"}, 32'(memBus.mem_cmd_oe), 32'd0);
        checkOutput({tag, "_dataOeDrop"}, 32'(memBus.mem_data_oe), 32'd0);
        checkOutput({tag, "_busyDrop"}, 32'(memBus.busy), 32'd0);
    endtask

    task automatic checkWriteRsp(input string tag, input int reqCycle);
        bit ok;
        waitForRsp(tag, reqCycle, ok);
        checkOutput({tag, "_cmd"}, 32'(memBus.mem_cmd_out), 32'(C2_RESPONSE));
        checkOutput({tag, "_dataOe"}, 32'(memBus.mem_data_oe), 32'd0);
        checkOutput({tag, "_busy"}, 32'(memBus.busy), 32'd1);
        tick();
        checkOutput({tag, "_cmdOeDrop"}, 32'(memBus.mem_cmd_oe), 32'd0);
        checkOutput({tag, "_busyDrop"}, 32'(memBus.busy), 32'd0);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_outs"},
                    {27'd0, memBus.mem_cmd_oe, memBus.mem_data_oe, memBus.busy, 2'(memBus.mem_cmd_out)},
                    32'd0);
        checkOutput({tag, "_data"}, 32'(memBus.mem_data_out), 32'd0);
    endtask

    initial begin
        int           req;
        int           dummy;
        logic [127:0] line;

`ifdef LINE_MEM_RAND_INIT_EN
        begin
            integer seedVar;
            seedVar = SEED;
            for (int l = 0; l < NLINES; l++) begin
                for (int b = 0; b < 16; b++) begin
                    model[l][8*b +: 8] = 8'($random(seedVar) & 8'hFF);
                end
            end
        end
`else
        for (int l = 0; l < NLINES; l++) model[l] = '0;
`endif

        memBus.mem_cmd_in  = C2_NOP;
        memBus.mem_address = '0;
        memBus.mem_data_in = '0;

        // Reset and idle behaviour, including an ignored RESPONSE command
        reset = 1'b1;
        tick();
        tick();
        checkIdle("inReset");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkIdle("idle");
        end
        applyStimulus(C2_RESPONSE, 15'h00A5, 16'hFFFF);
        memBus.mem_cmd_in = C2_NOP;
        checkIdle("ignoreRsp");

        // Write then read back line 0x00A5
        for (int k = 0; k < W; k++) line[16*k +: 16] = 16'(k + 1) * 16'h1111;
        issueWrite(15'h00A5, line, 1'b1, req);
        checkWriteRsp("wrA5", req);
        issueRead(15'h00A5, req);
        checkReadRsp("rdA5", req);

        // Unwritten line reflects initial contents
        issueRead(15'h0333, req);
        checkReadRsp("init", req);

        // Address wrap modulo NUM_LINES
        line = {8{16'hABCD}};
        issueWrite(15'h0005, line, 1'b1, req);
        checkWriteRsp("wrWrap", req);
        issueRead(15'h0405, req);
        checkReadRsp("wrap", req);

        // A write issued while a read is in flight is dropped
        for (int k = 0; k < W; k++) line[16*k +: 16] = 16'h0100 * 16'(k) + 16'h0010;
        issueWrite(15'h0010, line, 1'b1, req);
        checkWriteRsp("wr10", req);
        issueRead(15'h0010, req);
        while (cycle - req < 49) tick();
        issueWrite(15'h0020, {8{16'hDEAD}}, 1'b0, dummy);
        checkReadRsp("busyDrop", req);
        issueRead(15'h0020, req);
        checkReadRsp("dropUnchanged", req);

        // Reset in the middle of a read response clears outputs without a clock edge
        issueRead(15'h00A5, req);
        while (cycle - req < 103) tick();
        checkOutput("preReset_dataOe", 32'(memBus.mem_data_oe), 32'd1);
        reset = 1'b1;
        #1;
        checkIdle("midReset");
        #1;
        reset = 1'b0;
        expQ.delete();
        tick();
        issueRead(15'h00A5, req);
        checkReadRsp("afterReset", req);

        // Reset during write collection leaves the array untouched
        applyStimulus(C2_WRITE_LINE, 15'h0005, 16'h5555);
        applyStimulus(C2_NOP, 15'h0000, 16'h5555);
        applyStimulus(C2_NOP, 15'h0000, 16'h5555);
        reset = 1'b1;
        #1;
        checkIdle("partialWrReset");
        #1;
        reset = 1'b0;
        memBus.mem_data_in = '0;
        tick();
        issueRead(15'h0005, req);
        checkReadRsp("partialDiscard", req);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_mem.md
# line_mem

Parametrised main-memory model that serves whole cache lines to the cache over the 2-bit memory command bus and the BUS_SIZE-bit data bus. It generalises the fixed memory model of the cache lab: line size, bus width, depth and response latency are all parameters, and bus ownership is explicit through output enables. It sits below the cache. The top level resolves its split in/out/oe ports onto the shared tri-state memory bus.

## Interface
- BUS_SIZE, 16: data bus width in bits; must divide CACHE_LINE_SIZE*8.
- MEM_ADDR_SIZE, 19: byte address width.
- CACHE_OFFSET_SIZE, 4: log2(CACHE_LINE_SIZE).
- CACHE_LINE_SIZE, 16: line size in bytes.
- NUM_LINES, 2**(MEM_ADDR_SIZE-CACHE_OFFSET_SIZE): storage depth in lines; must be a power of 2.
- MEM_LATENCY, 100: cycles from request edge to response; must be >= W, where W = CACHE_LINE_SIZE*8/BUS_SIZE.
- SEED, 225526: random-init seed.
- clk, in, 1: clock, rising edge.
- reset, in, 1: asynchronous, active-high.
- mem_address, in, MEM_ADDR_SIZE-CACHE_OFFSET_SIZE: line address.
- mem_cmd_in, in, 2: command driven by the cache.
- mem_cmd_out, out, 2: command driven by this block.
- mem_cmd_oe, out, 1: this block owns the command bus.
- mem_data_in, in, BUS_SIZE: data driven by the cache.
- mem_data_out, out, BUS_SIZE: data driven by this block.
- mem_data_oe, out, 1: this block owns the data bus.
- busy, out, 1: a transaction is in progress.

## Operation
- Commands: C2_NOP=0, C2_RESPONSE=1, C2_READ_LINE=2, C2_WRITE_LINE=3.
- States:
  - IDLE -> WR_COLLECT on WRITE_LINE.
  - IDLE -> WAIT on READ_LINE.
  - WR_COLLECT -> WAIT after W words.
  - WAIT -> RD_SEND (read) or WR_ACK (write) when the latency counter expires.
  - RD_SEND -> IDLE after W words.
  - WR_ACK -> IDLE after 1 cycle.
- Line index = mem_address mod NUM_LINES; addresses wrap silently.
- Word order: word 0 is line bits [BUS_SIZE-1:0], ascending.
- The address is latched at the request edge only.
- In IDLE, NOP and RESPONSE are ignored.
- Outside IDLE, mem_cmd_in is ignored entirely. Requests issued while busy are dropped and produce no response.
- A write commits to the array on the edge that samples word W-1. A read issued after WR_ACK returns the new data.
- Reset outputs:
  - mem_cmd_out=C2_NOP, mem_data_out=0.
  - Both oe low, busy=0, state IDLE, counters 0.
- Reset does not alter the array contents.

## Timing
- The request edge is edge 0; all cycles below count from it.
- Write, data sampling:
  - Word 0 is sampled with WRITE_LINE at edge 0.
  - Words 1..W-1 are sampled at edges 1..W-1, whatever mem_cmd_in holds.
- Write, acknowledge:
  - From edge MEM_LATENCY, mem_cmd_out=RESPONSE and mem_cmd_oe=1 for exactly 1 cycle.
  - mem_data_oe stays 0.
- Read:
  - Over edges MEM_LATENCY .. MEM_LATENCY+W-1: cmd_oe=data_oe=1, mem_cmd_out=RESPONSE, mem_data_out = word k.
  - Both oe drop at edge MEM_LATENCY+W.
- busy rises at edge 0 and falls on the edge that returns to IDLE.
- A new request can be sampled on the first edge after busy falls.
- Asserting reset mid-transaction forces all outputs to their reset values immediately, without waiting for a clock edge.
- A partially collected write is discarded; the array is left untouched.

## Configuration
- LINE_MEM_RAND_INIT_EN defined: at time zero, each byte of the array is loaded with $random(SEED) & 8'hFF, filled line 0 first, byte 0 first.
- LINE_MEM_RAND_INIT_EN undefined: the array initialises to all zeros.
- The macro affects only initial contents. Timing and protocol are unchanged.

## Structure
- Package line_mem_pkg holds:
  - the cmd2_t enum (C2_* values);
  - the state_t enum;
  - a words_per_line(line_bytes, bus) function.
- The cache and cpu share cmd2_t from this package.
- Sub-module line_mem_array: NUM_LINES x CACHE_LINE_SIZE*8 storage with one line-wide write port and one combinational line read port.
- The holder of the LINE_MEM_RAND_INIT_EN initial block is line_mem_array.
- line_mem contains the FSM, the latency counter, the word counter and the word mux/demux.

## Test plan
Default parameters unless noted (W=8, MEM_LATENCY=100).
- Reset: pulse reset -> all oe=0, busy=0, mem_cmd_out=0, mem_data_out=0 at every cycle with no request.
- Write then read:
  - Write to line 0x00A5 with words 0x1111..0x8888 -> one RESPONSE at cycle 100.
  - A read of 0x00A5 issued at cycle 102 -> RESPONSE plus words 0x1111..0x8888 at cycles 202..209; oe low at 210.
- Wrap (NUM_LINES=1024): write line 0x0005 with 0xABCD in every word, then read line 0x0405 -> 8 x 0xABCD.
- Busy drop: READ_LINE 0x0010, then WRITE_LINE 0x0020 at cycle 50 -> only the read response appears (cycles 100..107); line 0x0020 is unchanged.
- Reset mid-read: assert reset at cycle 103 -> oe low immediately; a new read of 0x00A5 then completes normally with correct data.
- Init (macro undefined): read of an unwritten line 0x0333 -> 8 x 0x0000. With the macro defined, the data matches a reference model seeded with SEED.
